// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S slave receiver delivering {left, right} frames on a valid/ready port
module i2s_receiver #(
   parameter int DW = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i2s_bclk,
   input  logic            i2s_lrclk,
   input  logic            i2s_sdata,
   output logic [2*DW-1:0] out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            overflow,
   output logic            frame_err
);
   localparam int CW = $clog2(DW + 2);
   localparam logic [CW-1:0] CNT_DW = CW'(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DW + 1);
   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] bclk_s, lrclk_s, sdata_s;
   logic bclk_d, lrclk_prev;
   logic [CW-1:0] bit_cnt, cnt_next;
   logic [DW-2:0] shift;
   logic [DW-1:0] left, shift_next;
   logic sync_lrclk, rise, trans, full, capture, last;
   assign sync_lrclk = lrclk_s[SYNC_STAGES-1];
   assign rise = bclk_s[SYNC_STAGES-1] & ~bclk_d;
   assign trans = sync_lrclk != lrclk_prev;
   assign full = bit_cnt >= CNT_DW;
   assign cnt_next = bit_cnt == CNT_MAX ? CNT_MAX : bit_cnt + CW'(1);
   assign shift_next = {shift, sdata_s[SYNC_STAGES-1]};
   // the delay bit (lrclk change) is never data; bits 1..DW of a slot are
   assign capture = !trans && bit_cnt < CNT_DW;
   assign last = capture && bit_cnt == CNT_LAST;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bclk_s <= '0;
         lrclk_s <= '0;
         sdata_s <= '0;
         bclk_d <= 1'b0;
         lrclk_prev <= 1'b0;
         bit_cnt <= '0;
         shift <= '0;
         left <= '0;
         state <= SYNC;
         out_data <= '0;
         out_valid <= 1'b0;
         overflow <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         bclk_s <= {bclk_s[SYNC_STAGES-2:0], i2s_bclk};
         lrclk_s <= {lrclk_s[SYNC_STAGES-2:0], i2s_lrclk};
         sdata_s <= {sdata_s[SYNC_STAGES-2:0], i2s_sdata};
         bclk_d <= bclk_s[SYNC_STAGES-1];
         overflow <= 1'b0;
         frame_err <= 1'b0;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (rise) begin
            lrclk_prev <= sync_lrclk;
            bit_cnt <= trans ? '0 : cnt_next;
            if (capture) shift <= shift_next[DW-2:0];
            case (state)
               SYNC: if (trans && !sync_lrclk) state <= LEFT;
               LEFT: begin
                  if (last) left <= shift_next;
                  if (trans) begin
                     state <= full ? RIGHT : SYNC;
                     frame_err <= !full;
                  end
               end
               RIGHT: begin
                  if (last) begin
                     if (out_valid && !out_ready) overflow <= 1'b1;
                     else begin
                        out_data <= {left, shift_next};
                        out_valid <= 1'b1;
                     end
                  end
                  if (trans) begin
                     state <= full ? LEFT : SYNC;
                     frame_err <= !full;
                  end
               end
               default: state <= SYNC;
            endcase
         end
      end
   end
endmodule
